// File: rtl/popcount_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : popcount_pkg
//  Description : Shared types and elaboration-time helpers for the sequential
//                popcount engine: ceiling log2, ceiling division (number of
//                chunks per vector) and the controller state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package popcount_pkg;

    // Controller states: IDLE accepts, RUN accumulates, DONE presents result.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Smallest r with 2**r >= x (0 for x <= 1).
    function automatic int clog2_up(input int x);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < x) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Number of CHUNK-wide slices needed to cover n bits.
    function automatic int chunk_count(input int n, input int c);
        return (n + c - 1) / c;
    endfunction

endpackage : popcount_pkg
`default_nettype wire

// File: rtl/popcount_chunk.sv
`default_nettype none
// ============================================================================
//  Module      : popcount_chunk
//  Description : Combinational exact popcount of CHUNK bits, built as a
//                balanced binary adder tree over a power-of-two leaf set
//                (unused leaves are zero).
//  Ports       : i_bits  [CHUNK-1:0] bits to count
//                o_count [PCW-1:0]   number of ones in i_bits
//  Revision    : 1.0 - initial release
// ============================================================================
module popcount_chunk
    import popcount_pkg::*;
#(
    parameter  int CHUNK = 8,
    localparam int PCW   = clog2_up(CHUNK + 1)
) (
    input  logic [CHUNK-1:0] i_bits,
    output logic [PCW-1:0]   o_count
);

    localparam int LVL    = clog2_up(CHUNK);
    localparam int LEAVES = 1 << LVL;

    logic [PCW-1:0] w_tree [LEAVES];

    // Level l adds node j+2**l into node j for every j that is a multiple of
    // 2**(l+1); after the last level the root (index 0) holds the total.
    // Every partial sum is bounded by CHUNK, so PCW bits never overflow.
    always_comb begin
        for (int j = 0; j < LEAVES; j++) begin
            w_tree[j] = '0;
        end
        for (int j = 0; j < CHUNK; j++) begin
            w_tree[j] = PCW'(i_bits[j]);
        end
        for (int l = 0; l < LVL; l++) begin
            for (int j = 0; j < LEAVES; j += (2 << l)) begin
                w_tree[j] = w_tree[j] + w_tree[j + (1 << l)];
            end
        end
        o_count = w_tree[0];
    end

endmodule : popcount_chunk
`default_nettype wire

// File: rtl/popcount_seq_acc.sv
`default_nettype none
// ============================================================================
//  Module      : popcount_seq_acc
//  Description : Multi-cycle popcount engine for the ternary-neuron datapath.
//                A vector is accepted over valid/ready, counted CHUNK bits per
//                cycle into an accumulator, and returned with a threshold
//                flag. Approximate mode clears the low APPROX_LSBS result bits.
//  Ports       : clk, rst       clock (rising edge), synchronous active-high reset
//                in_valid/ready input handshake
//                in_data        activation bits (N_IN)
//                in_thresh      activation threshold (CW), captured on accept
//                approx_en      approximate mode, captured on accept
//                out_valid/ready result handshake
//                out_count      popcount, exact or truncated (CW)
//                out_ge         out_count >= captured threshold
//                busy           high while a vector is in flight (RUN/DONE)
//  Revision    : 1.0 - initial release
// ============================================================================
module popcount_seq_acc
    import popcount_pkg::*;
#(
    parameter  int N_IN        = 25,
    parameter  int CHUNK       = 8,
    parameter  int APPROX_LSBS = 1,
    localparam int CW          = clog2_up(N_IN + 1),
    localparam int NCHUNK      = chunk_count(N_IN, CHUNK)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N_IN-1:0] in_data,
    input  logic [CW-1:0]   in_thresh,
    input  logic            approx_en,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [CW-1:0]   out_count,
    output logic            out_ge,
    output logic            busy
);

    localparam int PW  = NCHUNK * CHUNK;          // zero-padded vector width
    localparam int PCW = clog2_up(CHUNK + 1);     // per-chunk count width
    localparam int IW  = clog2_up(NCHUNK + 1);    // chunk index must reach NCHUNK

    localparam logic [CW-1:0] c_keep_mask = ~CW'((1 << APPROX_LSBS) - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_accept;
    logic            w_finish;

    logic [PW-1:0]   r_data;
    logic [CW-1:0]   r_thresh;
    logic            r_approx;
    logic [CW-1:0]   r_acc;
    logic [IW-1:0]   r_idx;
    logic [CW-1:0]   r_count;
    logic            r_ge;

    logic [PCW-1:0]  w_chunk_cnt;
    logic [CW-1:0]   w_count;
    logic            w_ge;

    // The captured vector is shifted right each RUN cycle, so the chunk being
    // counted is always the low CHUNK bits.
    popcount_chunk #(
        .CHUNK   (CHUNK)
    ) u_chunk (
        .i_bits  (r_data[CHUNK-1:0]),
        .o_count (w_chunk_cnt)
    );

    assign w_count = r_approx ? (r_acc & c_keep_mask) : r_acc;
    assign w_ge    = (w_count >= r_thresh);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and handshake outputs
    // ------------------------------------------------------------------
    // RUN holds for NCHUNK+1 cycles: NCHUNK accumulate cycles, then one
    // finishing cycle (idx == NCHUNK) that registers count and flag so the
    // outputs are stable for the whole of DONE.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        w_accept    = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (r_idx == IW'(NCHUNK)) begin
                    w_finish    = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data   <= '0;
            r_thresh <= '0;
            r_approx <= 1'b0;
            r_acc    <= '0;
            r_idx    <= '0;
            r_count  <= '0;
            r_ge     <= 1'b0;
        end else if (w_accept) begin
            r_data   <= PW'(in_data);
            r_thresh <= in_thresh;
            r_approx <= approx_en;
            r_acc    <= '0;
            r_idx    <= '0;
        end else if (w_finish) begin
            r_count  <= w_count;
            r_ge     <= w_ge;
        end else if (r_state == ST_RUN) begin
            r_acc    <= r_acc + CW'(w_chunk_cnt);
            r_data   <= r_data >> CHUNK;
            r_idx    <= r_idx + IW'(1);
        end
    end

    assign out_count = r_count;
    assign out_ge    = r_ge;

endmodule : popcount_seq_acc
`default_nettype wire
